// File: rtl/rv_reduce_pkg.sv
// Shared types and helpers for the rv reduction sequencer.
// Define RV_REDUCE_SEQ_SIGNED_EN to sign-extend tree results into the accumulator.
package rv_reduce_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STREAM = 2'd1,
    DRAIN  = 2'd2,
    RESP   = 2'd3
  } seqState_t;

  function automatic int idWidth(input int r);
    return (r > 1) ? $clog2(r) : 1;
  endfunction

  function automatic int beatWidth(input int maxBeats);
    return $clog2(maxBeats + 1);
  endfunction

`ifdef RV_REDUCE_SEQ_SIGNED_EN
  localparam bit EXT_SIGNED = 1'b1;
`else
  localparam bit EXT_SIGNED = 1'b0;
`endif

endpackage

// File: rtl/rv_reduce_sequencer_if.sv
// Bundles requester, tree and response signals of the reduction sequencer.
// master = sequencer view, slave = requesters/tree/consumer view.
interface rv_reduce_sequencer_if #(
  parameter int N         = 4,
  parameter int DATAW     = 8,
  parameter int R         = 2,
  parameter int ACCW      = 16,
  parameter int MAX_BEATS = 15
);
  import rv_reduce_pkg::*;

  localparam int IDW = idWidth(R);
  localparam int BW  = beatWidth(MAX_BEATS);

  logic [R-1:0]         req_valid;
  logic [R-1:0]         req_last;
  logic [R*N*DATAW-1:0] req_data;
  logic [R-1:0]         req_ready;

  logic                 tree_en;
  logic [N*DATAW-1:0]   tree_data;
  logic [DATAW-1:0]     tree_dout;
  logic                 tree_active;

  logic                 rsp_valid;
  logic                 rsp_ready;
  logic [IDW-1:0]       rsp_id;
  logic [ACCW-1:0]      rsp_sum;
  logic [BW-1:0]        rsp_beats;
  logic                 rsp_ovf;

  modport master (
    input  req_valid, req_last, req_data, tree_dout, tree_active, rsp_ready,
    output req_ready, tree_en, tree_data, rsp_valid, rsp_id, rsp_sum, rsp_beats, rsp_ovf
  );

  modport slave (
    output req_valid, req_last, req_data, tree_dout, tree_active, rsp_ready,
    input  req_ready, tree_en, tree_data, rsp_valid, rsp_id, rsp_sum, rsp_beats, rsp_ovf
  );

endinterface

// File: rtl/rv_rr_arbiter.sv
// Combinational round-robin arbiter: first asserted request at or after i_ptr, wrapping.
module rv_rr_arbiter
  import rv_reduce_pkg::*;
#(
  parameter int R = 2,
  localparam int IDW = idWidth(R)
) (
  input  logic [R-1:0]   i_req,
  input  logic [IDW-1:0] i_ptr,
  input  logic           i_en,
  output logic [R-1:0]   o_grant,
  output logic [IDW-1:0] o_idx,
  output logic           o_valid
);

  always_comb begin : pick
    int j;
    o_grant = '0;
    o_idx   = '0;
    o_valid = 1'b0;
    j       = 0;
    for (int i = 0; i < R; i++) begin
      j = int'(i_ptr) + i;
      if (j >= R) j = j - R;
      if (i_en && !o_valid && i_req[j[IDW-1:0]]) begin
        o_valid              = 1'b1;
        o_grant[j[IDW-1:0]]  = 1'b1;
        o_idx                = j[IDW-1:0];
      end
    end
  end

endmodule

// File: rtl/rv_reduce_sequencer.sv
// Shares one adder-tree reduction datapath among R requesters and accumulates per-beat sums.
// Build option: RV_REDUCE_SEQ_SIGNED_EN selects sign-extension of tree results.
module rv_reduce_sequencer
  import rv_reduce_pkg::*;
#(
  parameter int N         = 4,
  parameter int DATAW     = 8,
  parameter int R         = 2,
  parameter int ACCW      = 16,
  parameter int MAX_BEATS = 15
) (
  input logic                  clk,
  input logic                  reset,
  rv_reduce_sequencer_if.master bus
);

  localparam int IDW   = idWidth(R);
  localparam int BW    = beatWidth(MAX_BEATS);
  localparam int LANEW = N * DATAW;

  seqState_t        r_state;
  logic [IDW-1:0]   r_grant;
  logic [IDW-1:0]   r_ptr;
  logic [R-1:0]     r_reqReady;
  logic [ACCW-1:0]  r_acc;
  logic [BW-1:0]    r_beats;
  logic             r_ovf;
  logic             r_rspValid;
  logic [IDW-1:0]   r_rspId;
  logic [ACCW-1:0]  r_rspSum;
  logic [BW-1:0]    r_rspBeats;
  logic             r_rspOvf;

  logic [R-1:0]     w_arbGrant;
  logic [IDW-1:0]   w_arbIdx;
  logic             w_arbValid;
  logic             w_streaming;
  logic             w_grantValid;
  logic             w_grantLast;
  logic [LANEW-1:0] w_grantData;
  logic             w_beatAcc;
  logic [ACCW-1:0]  w_extSigned;
  logic [ACCW-1:0]  w_extUnsigned;
  logic [ACCW-1:0]  w_ext;
  logic [ACCW-1:0]  w_accNext;

  rv_rr_arbiter #(.R(R)) u_arb (
    .i_req   (bus.req_valid),
    .i_ptr   (r_ptr),
    .i_en    (r_state == IDLE),
    .o_grant (w_arbGrant),
    .o_idx   (w_arbIdx),
    .o_valid (w_arbValid)
  );

  assign w_streaming  = (r_state == STREAM);
  assign w_grantValid = bus.req_valid[r_grant];
  assign w_grantLast  = bus.req_last[r_grant];
  assign w_grantData  = bus.req_data[r_grant*LANEW +: LANEW];
  assign w_beatAcc    = w_streaming & w_grantValid;

  // Tree path is combinational from the locked grant so a beat enters the tree the cycle it is accepted.
  assign bus.tree_en   = w_beatAcc;
  assign bus.tree_data = w_streaming ? w_grantData : '0;
  assign bus.req_ready = r_reqReady;

  assign w_extSigned   = ACCW'($signed(bus.tree_dout));
  assign w_extUnsigned = ACCW'(bus.tree_dout);
  assign w_ext         = EXT_SIGNED ? w_extSigned : w_extUnsigned;
  assign w_accNext     = r_acc + (bus.tree_active ? w_ext : '0);

  assign bus.rsp_valid = r_rspValid;
  assign bus.rsp_id    = r_rspId;
  assign bus.rsp_sum   = r_rspSum;
  assign bus.rsp_beats = r_rspBeats;
  assign bus.rsp_ovf   = r_rspOvf;

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state    <= IDLE;
      r_grant    <= '0;
      r_ptr      <= '0;
      r_reqReady <= '0;
      r_acc      <= '0;
      r_beats    <= '0;
      r_ovf      <= 1'b0;
      r_rspValid <= 1'b0;
      r_rspId    <= '0;
      r_rspSum   <= '0;
      r_rspBeats <= '0;
      r_rspOvf   <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_arbValid) begin
            r_grant    <= w_arbIdx;
            r_reqReady <= w_arbGrant;
            r_acc      <= '0;
            r_beats    <= '0;
            r_ovf      <= 1'b0;
            r_ptr      <= (w_arbIdx == IDW'(R - 1)) ? '0 : w_arbIdx + 1'b1;
            r_state    <= STREAM;
          end
        end
        STREAM: begin
          r_acc <= w_accNext;
          if (w_beatAcc) begin
            if (r_beats == BW'(MAX_BEATS)) r_ovf   <= 1'b1;
            else                            r_beats <= r_beats + 1'b1;
            if (w_grantLast) begin
              r_reqReady <= '0;
              r_state    <= DRAIN;
            end
          end
        end
        // The last beat's tree result lands here, so the response captures the post-add value.
        DRAIN: begin
          r_acc      <= w_accNext;
          r_rspSum   <= w_accNext;
          r_rspId    <= r_grant;
          r_rspBeats <= r_beats;
          r_rspOvf   <= r_ovf;
          r_rspValid <= 1'b1;
          r_state    <= RESP;
        end
        RESP: begin
          if (bus.rsp_ready) begin
            r_rspValid <= 1'b0;
            r_state    <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rv_reduce_sequencer.sv
// Directed bench for rv_reduce_sequencer with a 1-cycle adder-tree model.
// Expected sums follow RV_REDUCE_SEQ_SIGNED_EN when defined.
module tb_rv_reduce_sequencer;
  import rv_reduce_pkg::*;

  localparam int N         = 4;
  localparam int DATAW     = 8;
  localparam int R         = 2;
  localparam int ACCW      = 16;
  localparam int MAX_BEATS = 15;
  localparam int LANEW     = N * DATAW;

  logic clk = 1'b0;
  logic reset = 1'b0;
  int   vectors = 0;
  int   miscompares = 0;

  rv_reduce_sequencer_if #(.N(N), .DATAW(DATAW), .R(R), .ACCW(ACCW), .MAX_BEATS(MAX_BEATS)) bus ();

  rv_reduce_sequencer #(.N(N), .DATAW(DATAW), .R(R), .ACCW(ACCW), .MAX_BEATS(MAX_BEATS)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [DATAW-1:0] laneSum(input logic [LANEW-1:0] d);
    logic [DATAW-1:0] s;
    s = '0;
    for (int i = 0; i < N; i++) s = s + d[i*DATAW +: DATAW];
    return s;
  endfunction

  // Reference tree: registered lane sum, wrapping at DATAW bits.
  always_ff @(posedge clk) begin
    if (!reset) begin
      bus.tree_dout   <= '0;
      bus.tree_active <= 1'b0;
    end else begin
      bus.tree_active <= bus.tree_en;
      if (bus.tree_en) bus.tree_dout <= laneSum(bus.tree_data);
    end
  end

  function automatic logic [LANEW-1:0] mk(input logic [7:0] l0, l1, l2, l3);
    return {l3, l2, l1, l0};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic sendBeat(input int r, input logic [LANEW-1:0] d, input logic last);
    int waited;
    waited = 0;
    bus.req_valid[r] = 1'b1;
    bus.req_last[r]  = last;
    bus.req_data[r*LANEW +: LANEW] = d;
    while (!bus.req_ready[r] && waited < 20) begin
      tick();
      waited++;
    end
    vectors++;
    if (bus.req_ready[r] !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL beat_ready r%0d: req_ready=%b, required 1 within 20 cycles", r, bus.req_ready[r]);
    end
    tick();
    bus.req_valid[r] = 1'b0;
    bus.req_last[r]  = 1'b0;
  endtask

  task automatic waitRsp(input string tag);
    int waited;
    waited = 0;
    while (bus.rsp_valid !== 1'b1 && waited < 40) begin
      tick();
      waited++;
    end
    vectors++;
    if (bus.rsp_valid !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL %s_rsp_timeout: rsp_valid=%b, required 1 within 40 cycles", tag, bus.rsp_valid);
    end
  endtask

  task automatic handshake(input string tag);
    bus.rsp_ready = 1'b1;
    tick();
    bus.rsp_ready = 1'b0;
    vectors++;
    if (bus.rsp_valid !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL %s_rsp_drop: rsp_valid=%b, required 0", tag, bus.rsp_valid);
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    tick();
    tick();
    vectors++; if (bus.req_ready !== 2'b00) begin miscompares++; $display("[TB] FAIL reset_req_ready: got %b, want 00", bus.req_ready); end
    vectors++; if (bus.tree_en !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_tree_en: got %b, want 0", bus.tree_en); end
    vectors++; if (bus.tree_data !== '0) begin miscompares++; $display("[TB] FAIL reset_tree_data: got %h, want 0", bus.tree_data); end
    vectors++; if (bus.rsp_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_rsp_valid: got %b, want 0", bus.rsp_valid); end
    vectors++; if (bus.rsp_sum !== '0) begin miscompares++; $display("[TB] FAIL reset_rsp_sum: got %h, want 0", bus.rsp_sum); end
    vectors++; if ({bus.rsp_id, bus.rsp_beats, bus.rsp_ovf} !== '0) begin miscompares++; $display("[TB] FAIL reset_rsp_fields: id=%0d beats=%0d ovf=%b, want 0", bus.rsp_id, bus.rsp_beats, bus.rsp_ovf); end
    reset = 1'b1;
    tick();
  endtask

  task automatic test_single();
    sendBeat(0, mk(8'd1, 8'd2, 8'd3, 8'd4), 1'b0);
    sendBeat(0, mk(8'd5, 8'd6, 8'd7, 8'd8), 1'b1);
    waitRsp("single");
    vectors++; if (bus.rsp_id !== 1'b0) begin miscompares++; $display("[TB] FAIL single_id: got %0d, want 0", bus.rsp_id); end
    vectors++; if (bus.rsp_sum !== 16'd36) begin miscompares++; $display("[TB] FAIL single_sum: got %0d, want 36", bus.rsp_sum); end
    vectors++; if (bus.rsp_beats !== 4'd2) begin miscompares++; $display("[TB] FAIL single_beats: got %0d, want 2", bus.rsp_beats); end
    vectors++; if (bus.rsp_ovf !== 1'b0) begin miscompares++; $display("[TB] FAIL single_ovf: got %b, want 0", bus.rsp_ovf); end
    handshake("single");
  endtask

  task automatic test_back_to_back();
    int waited;
    int expId;
    logic [ACCW-1:0] expSum;
    logic [R-1:0]    expReady;
    reset = 1'b0;
    tick();
    reset = 1'b1;
    bus.req_data[0*LANEW +: LANEW] = mk(8'd1, 8'd1, 8'd1, 8'd2);
    bus.req_data[1*LANEW +: LANEW] = mk(8'd2, 8'd2, 8'd2, 8'd3);
    bus.req_last  = 2'b11;
    bus.req_valid = 2'b11;
    bus.rsp_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      expId  = k % 2;
      expSum = (expId == 0) ? 16'd5 : 16'd9;
      waited = 0;
      while (bus.rsp_valid !== 1'b1 && waited < 40) begin
        tick();
        waited++;
      end
      vectors++; if (bus.rsp_id !== expId[0] || bus.rsp_valid !== 1'b1) begin miscompares++; $display("[TB] FAIL rr_id pkt%0d: got id=%0d valid=%b, want id=%0d valid=1", k, bus.rsp_id, bus.rsp_valid, expId); end
      vectors++; if (bus.rsp_sum !== expSum) begin miscompares++; $display("[TB] FAIL rr_sum pkt%0d: got %0d, want %0d", k, bus.rsp_sum, expSum); end
      tick();
      vectors++; if (bus.rsp_valid !== 1'b0 || bus.req_ready !== 2'b00) begin miscompares++; $display("[TB] FAIL rr_idle_gap pkt%0d: rsp_valid=%b req_ready=%b, want 0/00", k, bus.rsp_valid, bus.req_ready); end
      if (k < 3) begin
        tick();
        expReady = (expId == 0) ? 2'b10 : 2'b01;
        vectors++; if (bus.req_ready !== expReady) begin miscompares++; $display("[TB] FAIL rr_next_grant pkt%0d: req_ready=%b, want %b", k, bus.req_ready, expReady); end
      end
    end
    bus.req_valid = 2'b00;
    bus.req_last  = 2'b00;
    bus.rsp_ready = 1'b0;
    tick();
  endtask

  task automatic test_wrap();
    logic [ACCW-1:0] expSum;
`ifdef RV_REDUCE_SEQ_SIGNED_EN
    expSum = 16'hFFFE;
`else
    expSum = 16'h01FE;
`endif
    sendBeat(1, mk(8'd255, 8'd255, 8'd1, 8'd0), 1'b0);
    sendBeat(1, mk(8'd255, 8'd255, 8'd1, 8'd0), 1'b1);
    waitRsp("wrap");
    vectors++; if (bus.rsp_sum !== expSum) begin miscompares++; $display("[TB] FAIL wrap_sum: got %h, want %h", bus.rsp_sum, expSum); end
    vectors++; if (bus.rsp_id !== 1'b1) begin miscompares++; $display("[TB] FAIL wrap_id: got %0d, want 1", bus.rsp_id); end
    vectors++; if (bus.rsp_beats !== 4'd2) begin miscompares++; $display("[TB] FAIL wrap_beats: got %0d, want 2", bus.rsp_beats); end
    handshake("wrap");
  endtask

  task automatic test_hold();
    sendBeat(0, mk(8'd7, 8'd0, 8'd0, 8'd0), 1'b1);
    waitRsp("hold");
    bus.req_data[1*LANEW +: LANEW] = mk(8'd9, 8'd9, 8'd9, 8'd9);
    bus.req_last[1]  = 1'b1;
    bus.req_valid[1] = 1'b1;
    for (int c = 0; c < 5; c++) begin
      vectors++; if (bus.rsp_valid !== 1'b1 || bus.rsp_sum !== 16'd7 || bus.rsp_id !== 1'b0 || bus.rsp_beats !== 4'd1 || bus.rsp_ovf !== 1'b0) begin
        miscompares++; $display("[TB] FAIL hold_rsp c%0d: valid=%b sum=%0d id=%0d beats=%0d ovf=%b, want 1/7/0/1/0", c, bus.rsp_valid, bus.rsp_sum, bus.rsp_id, bus.rsp_beats, bus.rsp_ovf);
      end
      vectors++; if (bus.req_ready !== 2'b00 || bus.tree_en !== 1'b0) begin miscompares++; $display("[TB] FAIL hold_quiet c%0d: req_ready=%b tree_en=%b, want 00/0", c, bus.req_ready, bus.tree_en); end
      tick();
    end
    bus.rsp_ready = 1'b1;
    tick();
    bus.rsp_ready    = 1'b0;
    bus.req_valid[1] = 1'b0;
    bus.req_last[1]  = 1'b0;
    vectors++; if (bus.rsp_valid !== 1'b0 || bus.req_ready !== 2'b00) begin miscompares++; $display("[TB] FAIL hold_release: rsp_valid=%b req_ready=%b, want 0/00", bus.rsp_valid, bus.req_ready); end
    tick();
  endtask

  task automatic test_overflow();
    for (int b = 0; b < 16; b++) sendBeat(0, mk(8'd1, 8'd0, 8'd0, 8'd0), (b == 15));
    waitRsp("ovf");
    vectors++; if (bus.rsp_beats !== 4'd15) begin miscompares++; $display("[TB] FAIL ovf_beats: got %0d, want 15", bus.rsp_beats); end
    vectors++; if (bus.rsp_ovf !== 1'b1) begin miscompares++; $display("[TB] FAIL ovf_flag: got %b, want 1", bus.rsp_ovf); end
    vectors++; if (bus.rsp_sum !== 16'd16) begin miscompares++; $display("[TB] FAIL ovf_sum: got %0d, want 16", bus.rsp_sum); end
    handshake("ovf");
  endtask

  task automatic test_reset_mid();
    sendBeat(0, mk(8'd1, 8'd1, 8'd1, 8'd1), 1'b0);
    sendBeat(0, mk(8'd1, 8'd1, 8'd1, 8'd1), 1'b0);
    reset = 1'b0;
    tick();
    vectors++; if (bus.req_ready !== 2'b00 || bus.tree_en !== 1'b0 || bus.tree_data !== '0) begin miscompares++; $display("[TB] FAIL midreset_req_tree: req_ready=%b tree_en=%b tree_data=%h, want 0", bus.req_ready, bus.tree_en, bus.tree_data); end
    vectors++; if (bus.rsp_valid !== 1'b0 || bus.rsp_sum !== '0 || bus.rsp_beats !== '0) begin miscompares++; $display("[TB] FAIL midreset_rsp: valid=%b sum=%0d beats=%0d, want 0", bus.rsp_valid, bus.rsp_sum, bus.rsp_beats); end
    reset = 1'b1;
    for (int c = 0; c < 4; c++) begin
      tick();
      vectors++; if (bus.rsp_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL midreset_no_rsp c%0d: rsp_valid=%b, want 0", c, bus.rsp_valid); end
    end
    bus.req_data[0*LANEW +: LANEW] = mk(8'd3, 8'd0, 8'd0, 8'd0);
    bus.req_data[1*LANEW +: LANEW] = mk(8'd9, 8'd0, 8'd0, 8'd0);
    bus.req_last  = 2'b11;
    bus.req_valid = 2'b11;
    waitRsp("midreset");
    bus.req_valid = 2'b00;
    bus.req_last  = 2'b00;
    vectors++; if (bus.rsp_id !== 1'b0) begin miscompares++; $display("[TB] FAIL midreset_ptr: rsp_id=%0d, want 0", bus.rsp_id); end
    vectors++; if (bus.rsp_sum !== 16'd3) begin miscompares++; $display("[TB] FAIL midreset_sum: got %0d, want 3", bus.rsp_sum); end
    handshake("midreset");
    tick();
  endtask

  initial begin
    bus.req_valid = '0;
    bus.req_last  = '0;
    bus.req_data  = '0;
    bus.rsp_ready = 1'b0;
    $display("[TB] starting rv_reduce_sequencer directed tests");
    test_reset();
    test_single();
    test_back_to_back();
    test_wrap();
    test_hold();
    test_overflow();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
